// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad emulator.
//   key_code_t   : {row_idx[1:0], col_idx[1:0]}
//   state_t      : emulator FSM states
//   row_onehot() : 2-bit row index -> one-hot row lines (index 0 = 4'b1000)
//   col_onehot() : 2-bit col index -> one-hot column strobe (index 0 = 4'b1000)
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StGap
    } state_t;

    function automatic logic [3:0] row_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

    function automatic logic [3:0] col_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous FIFO holding queued key codes.
//   clk, rst : clock, synchronous active-high reset (flushes the queue)
//   push/din : write din when push is high and the queue is not full
//   pop/dout : dout shows the head; pop advances it when the queue is not empty
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of 2 so the pointers wrap naturally.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [3:0] din,
    input  logic       pop,
    output logic [3:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    key_code_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            // Simultaneous push and pop leaves the count unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: plays queued key codes into a 4x4 matrix-keypad scanner.
//   clk, rst   : clock, synchronous active-high reset
//   col        : one-hot column strobe from the scanner (4'b1000 = col 0)
//   row        : row lines back to the scanner (4'b1000 = row 0), combinational
//   key_valid  : key_code offered; accepted when key_ready is high
//   key_code   : {row_idx, col_idx}
//   key_ready  : queue can take a key
//   busy       : queue non-empty or a key in progress
//   key_done   : one-cycle pulse on the last gap cycle of each key
// Each key is held for HOLD_CYCLES cycles, then released for GAP_CYCLES cycles.
// Build option KEY_BOUNCE_EN: the first BOUNCE_CYCLES press cycles chatter
// (asserted, released, ...) before the stable HOLD_CYCLES period.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned BOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       key_done
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    // Gap count one cycle before the last, so key_done can be registered.
    localparam logic [7:0] GAP_PRE   = 8'(GAP_CYCLES - 2);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    key_code_t  cur_key;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_head;
    logic       push;
    logic       pop;

`ifdef KEY_BOUNCE_EN
    localparam logic [7:0] BOUNCE_LAST = 8'(BOUNCE_CYCLES - 1);
    logic bouncing;
`else
    logic unused_bounce;
    assign unused_bounce = ^BOUNCE_CYCLES;
`endif

    assign key_ready = !fifo_full && !rst;
    assign push      = key_valid && key_ready;
    assign pop       = (state == StIdle) && !fifo_empty;
    assign busy      = (state != StIdle) || !fifo_empty;
    // Counters hold at their terminal value instead of wrapping.
    assign cnt_inc   = (cnt == 8'hff) ? cnt : cnt + 8'd1;

    key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (key_code),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            cur_key  <= '0;
            key_done <= 1'b0;
`ifdef KEY_BOUNCE_EN
            bouncing <= 1'b0;
`endif
        end else begin
            key_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        cur_key  <= fifo_head;
                        cnt      <= '0;
                        state    <= StPress;
`ifdef KEY_BOUNCE_EN
                        bouncing <= 1'b1;
`endif
                    end
                end
                StPress: begin
`ifdef KEY_BOUNCE_EN
                    if (bouncing) begin
                        if (cnt == BOUNCE_LAST) begin
                            bouncing <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else
`endif
                    if (cnt == HOLD_LAST) begin
                        state    <= StGap;
                        cnt      <= '0;
                        // A one-cycle gap is its own last cycle.
                        key_done <= (GAP_CYCLES == 1);
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                StGap: begin
                    if (cnt == GAP_LAST) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else begin
                        cnt      <= cnt_inc;
                        key_done <= (cnt == GAP_PRE);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Row follows the scanner's column strobe with no register in between;
    // any strobe that includes the key's column closes the contact.
    always_comb begin
        row = 4'b0000;
        if (state == StPress && |(col & col_onehot(cur_key[1:0]))) begin
            row = row_onehot(cur_key[3:2]);
        end
`ifdef KEY_BOUNCE_EN
        if (bouncing && cnt[0]) row = 4'b0000;
`endif
    end

endmodule
